iter_shift_ctrl: RTL and testbench

- Multi-cycle shift/rotate unit for the execute stage.
- Holds a 16-bit operand in an accumulator and applies one shift-by-1 step per clock until the requested amount is consumed. One start/done handshake per operation.
- Used as a low-area alternative to the full barrel shifter. It uses the same 2-bit op encoding.

---
 rtl/iter_shift_ctrl.sv | 115 +++++++++++
 tb/tb_iter_shift_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_shift_ctrl.sv
// Multi-cycle shift/rotate unit: one shift-by-1 step per clock until the amount is consumed.
// Optional macro ITER_SHIFT_ROT_SHORT_EN turns long rotates into the shorter opposite rotate.
module iter_shift_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;

    logic [WIDTH-1:0]   acc_d;
    logic [CNT_W-1:0]   cntLoad;
    logic [1:0]         opLoad;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] a, input logic [1:0] o);
        case (o)
            2'b00:   step = {a[WIDTH-2:0], a[WIDTH-1]};
            2'b01:   step = {a[WIDTH-2:0], 1'b0};
            2'b10:   step = {a[0], a[WIDTH-1:1]};
            default: step = {1'b0, a[WIDTH-1:1]};
        endcase
    endfunction

    assign acc_d = step(acc_q, op_q);

`ifdef ITER_SHIFT_ROT_SHORT_EN
    localparam int HALF = 2 ** (CNT_W - 1);
    logic useShort;

    // A rotate by more than half the width equals the opposite rotate by the complement.
    assign useShort = !op[0] && (amt > HALF[CNT_W-1:0]);
    assign cntLoad  = useShort ? (CNT_W'(0) - amt) : amt;
    assign opLoad   = useShort ? {~op[1], op[0]} : op;
`else
    assign cntLoad  = amt;
    assign opLoad   = op;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        acc_q  <= data_in;
                        cnt_q  <= cntLoad;
                        op_q   <= opLoad;
                        busy_q <= 1'b1;
                        if (cntLoad == '0) begin
                            state_q  <= FIN;
                            done_q   <= 1'b1;
                            result_q <= data_in;
                        end else begin
                            state_q  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    // Result is captured on the way into FIN so it lines up with done.
                    if (cnt_q == CNT_W'(1)) begin
                        state_q  <= FIN;
                        done_q   <= 1'b1;
                        result_q <= acc_d;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_iter_shift_ctrl.sv
// Scoreboard bench for iter_shift_ctrl; expected result/latency queued at launch, checked at done.
module tb_iter_shift_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [3:0]  amt;
    logic [15:0] data_in;
    logic        busy;
    logic        done;
    logic [15:0] result;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] res;
        int          lat;
    } exp_t;

    exp_t sbQ[$];

    iter_shift_ctrl #(.WIDTH(16), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .amt     (amt),
        .data_in (data_in),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference result computed from a doubled word rather than bit-by-bit stepping.
    function automatic logic [15:0] modelRes(input logic [1:0] o, input logic [3:0] n, input logic [15:0] d);
        logic [31:0] dd;
        logic [31:0] t;
        dd = {d, d};
        case (o)
            2'b00: begin t = dd << n; modelRes = t[31:16]; end
            2'b01: modelRes = d << n;
            2'b10: begin t = dd >> n; modelRes = t[15:0]; end
            default: modelRes = d >> n;
        endcase
    endfunction

    function automatic int modelLat(input logic [1:0] o, input logic [3:0] n);
`ifdef ITER_SHIFT_ROT_SHORT_EN
        if (!o[0] && n > 4'd8) return 16 - int'(n) + 1;
`endif
        return int'(n) + 1;
    endfunction

    // Drives one accepted request (must be called in IDLE) and scrambles inputs afterwards.
    task automatic applyStimulus(input logic [1:0] o, input logic [3:0] n, input logic [15:0] d);
        exp_t e;
        e.res = modelRes(o, n, d);
        e.lat = modelLat(o, n);
        sbQ.push_back(e);
        start   = 1'b1;
        op      = o;
        amt     = n;
        data_in = d;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 2'($urandom);
        amt     = 4'($urandom);
        data_in = 16'($urandom);
    endtask

    // Counts cycles after acceptance until done; lat stays 0 if the bound expires.
    task automatic waitDone(input int limit, output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        for (int k = 1; k <= limit; k++) begin
            if (busy) busyCnt++;
            if (done) begin
                lat = k;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic runOp(input logic [1:0] o, input logic [3:0] n, input logic [15:0] d,
                         output logic [15:0] res, output int lat, output int busyCnt);
        applyStimulus(o, n, d);
        waitDone(40, lat, busyCnt);
        res = result;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start = 1'b0;
        op = 2'b00;
        amt = 4'd0;
        data_in = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done got=%b want=0", done); end
        compared++;
        if (result !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_result got=%h want=0000", result); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rotate_left;
        logic [15:0] res;
        int lat, bc;
        exp_t e;
        runOp(2'b00, 4'd1, 16'h8001, res, lat, bc);
        e = sbQ.pop_front();
        compared++;
        if (res !== e.res) begin mismatched++; $display("[TB] FAIL rol_result got=%h want=%h", res, e.res); end
        compared++;
        if (lat !== e.lat) begin mismatched++; $display("[TB] FAIL rol_latency got=%0d want=%0d", lat, e.lat); end
        compared++;
        if (bc !== e.lat) begin mismatched++; $display("[TB] FAIL rol_busy_cycles got=%0d want=%0d", bc, e.lat); end
        @(posedge clk);
        #1;
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL rol_done_pulse got=%b want=0", done); end
        compared++;
        if (result !== e.res) begin mismatched++; $display("[TB] FAIL rol_result_hold got=%h want=%h", result, e.res); end
    endtask

    task automatic test_shift;
        logic [15:0] res;
        int lat, bc;
        exp_t e;
        runOp(2'b01, 4'd4, 16'h00FF, res, lat, bc);
        e = sbQ.pop_front();
        compared++;
        if (res !== e.res) begin mismatched++; $display("[TB] FAIL shl_result got=%h want=%h", res, e.res); end
        compared++;
        if (lat !== e.lat) begin mismatched++; $display("[TB] FAIL shl_latency got=%0d want=%0d", lat, e.lat); end
        @(posedge clk);
        #1;
        runOp(2'b11, 4'd15, 16'h8000, res, lat, bc);
        e = sbQ.pop_front();
        compared++;
        if (res !== e.res) begin mismatched++; $display("[TB] FAIL shr_result got=%h want=%h", res, e.res); end
        compared++;
        if (lat !== e.lat) begin mismatched++; $display("[TB] FAIL shr_latency got=%0d want=%0d", lat, e.lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_rotate_right;
        logic [15:0] res;
        int lat, bc;
        exp_t e;
        runOp(2'b10, 4'd15, 16'h0001, res, lat, bc);
        e = sbQ.pop_front();
        compared++;
        if (res !== e.res) begin mismatched++; $display("[TB] FAIL ror_result got=%h want=%h", res, e.res); end
        compared++;
        if (lat !== e.lat) begin mismatched++; $display("[TB] FAIL ror_latency got=%0d want=%0d", lat, e.lat); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero_amt;
        logic [15:0] res;
        int lat, bc;
        exp_t e;
        runOp(2'b11, 4'd0, 16'hA5A5, res, lat, bc);
        e = sbQ.pop_front();
        compared++;
        if (res !== e.res) begin mismatched++; $display("[TB] FAIL zero_result got=%h want=%h", res, e.res); end
        compared++;
        if (lat !== e.lat) begin mismatched++; $display("[TB] FAIL zero_latency got=%0d want=%0d", lat, e.lat); end
        compared++;
        if (bc !== 1) begin mismatched++; $display("[TB] FAIL zero_busy_cycles got=%0d want=1", bc); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_start_while_busy;
        int lat;
        exp_t e;
        applyStimulus(2'b01, 4'd8, 16'h0001);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 3) begin
                start = 1'b1;
                op = 2'b11;
                amt = 4'd0;
                data_in = 16'hFFFF;
            end else if (k == 4) begin
                start = 1'b0;
            end else if (k >= 5) begin
                start = 1'b1;
            end
            if (done) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        e = sbQ.pop_front();
        compared++;
        if (result !== e.res) begin mismatched++; $display("[TB] FAIL busy_ignore_result got=%h want=%h", result, e.res); end
        compared++;
        if (lat !== e.lat) begin mismatched++; $display("[TB] FAIL busy_ignore_latency got=%0d want=%0d", lat, e.lat); end
        @(posedge clk);
        #1;
        start = 1'b0;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL fin_no_retrigger got=%b want=0", busy); end
        @(posedge clk);
        #1;
        compared++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_after_fin got=busy%b/done%b want=busy0/done0", busy, done);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [15:0] res;
        int lat, bc;
        bit sawDone;
        exp_t e;
        applyStimulus(2'b00, 4'd10, 16'h1234);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy got=%b want=0", busy); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_done got=%b want=0", done); end
        compared++;
        if (result !== 16'h0) begin mismatched++; $display("[TB] FAIL midrst_result got=%h want=0000", result); end
        void'(sbQ.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        compared++;
        if (sawDone !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_no_done got=%b want=0", sawDone); end
        runOp(2'b01, 4'd2, 16'h0005, res, lat, bc);
        e = sbQ.pop_front();
        compared++;
        if (res !== e.res || lat !== e.lat) begin
            mismatched++;
            $display("[TB] FAIL midrst_recover got=%h/%0d want=%h/%0d", res, lat, e.res, e.lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [15:0] res;
        int lat, bc;
        exp_t e;
        runOp(2'b01, 4'd3, 16'h0003, res, lat, bc);
        e = sbQ.pop_front();
        compared++;
        if (res !== e.res || lat !== e.lat) begin
            mismatched++;
            $display("[TB] FAIL b2b_first got=%h/%0d want=%h/%0d", res, lat, e.res, e.lat);
        end
        @(posedge clk);
        #1;
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_idle_busy got=%b want=0", busy); end
        runOp(2'b10, 4'd2, 16'h0003, res, lat, bc);
        e = sbQ.pop_front();
        compared++;
        if (res !== e.res || lat !== e.lat) begin
            mismatched++;
            $display("[TB] FAIL b2b_second got=%h/%0d want=%h/%0d", res, lat, e.res, e.lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [15:0] res;
        int lat, bc;
        exp_t e;
        for (int i = 0; i < 12; i++) begin
            runOp(2'($urandom), 4'($urandom), 16'($urandom), res, lat, bc);
            e = sbQ.pop_front();
            compared++;
            if (res !== e.res || lat !== e.lat || bc !== e.lat) begin
                mismatched++;
                $display("[TB] FAIL random_%0d got=%h/%0d/%0d want=%h/%0d/%0d",
                         i, res, lat, bc, e.res, e.lat, e.lat);
            end
            repeat (1 + (i % 2)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        test_reset;
        test_rotate_left;
        test_shift;
        test_rotate_right;
        test_zero_amt;
        test_start_while_busy;
        test_reset_mid_op;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
